// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter.
// Holds FSM state encodings, the requester ID type and the read latency.
package ram_arb_pkg;

  typedef logic [0:0] ram_arb_state_t;
  localparam ram_arb_state_t IDLE   = 1'b0;
  localparam ram_arb_state_t RD_CAP = 1'b1;

  typedef logic req_id_t;

  localparam int RD_LATENCY = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with an optional read-only restriction.
// Writes are masked while the RAM output is being captured.
import ram_arb_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] req_we,
  input  logic       rd_only,
  output logic [1:0] gnt,
  output logic       upd
);

  logic [1:0] elig;
  req_id_t    last;

  assign elig = req
              & ~({2{rd_only}} & req_we)
              & {2{~rst}};

  // On contention, favour whoever was not granted last.
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (elig == 2'b11): gnt = last ? 2'b01 : 2'b10;
      default:         gnt = elig;
    endcase
  end

  assign upd = |gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and control sequencer for the single-port RAM.
// Reads return on rspN_* two cycles after grant.
import ram_arb_pkg::*;

module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  ram_arb_state_t        state;
  req_id_t               owner;
  logic [1:0]            gnt;
  logic                  any_gnt;
  req_id_t               sel;
  logic                  g_we;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic                  rd_gnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .req_we  ({req1_we, req0_we}),
    .rd_only (state == RD_CAP),
    .gnt     (gnt),
    .upd     (any_gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign sel     = gnt[1];
  assign g_we    = sel ? req1_we    : req0_we;
  assign g_addr  = sel ? req1_addr  : req0_addr;
  assign g_wdata = sel ? req1_wdata : req0_wdata;
  assign rd_gnt  = any_gnt & ~g_we;

  // RD_CAP keeps the RAM output enabled so the registered read can be captured.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_oe   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (any_gnt) begin
      ram_cs   = 1'b1;
      ram_we   = g_we;
      ram_oe   = ~g_we;
      ram_addr = g_addr;
      ram_din  = g_we ? g_wdata : '0;
    end else if (state == RD_CAP) begin
      ram_cs   = 1'b1;
      ram_oe   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= rd_gnt ? RD_CAP : IDLE;
      if (rd_gnt) begin
        owner <= sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= (state == RD_CAP) && (owner == 1'b0);
      rsp1_valid <= (state == RD_CAP) && (owner == 1'b1);
      if (state == RD_CAP) begin
        if (owner) begin
          rsp1_rdata <= ram_dout;
        end else begin
          rsp0_rdata <= ram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter against a transaction-level model.
// Includes a registered-read RAM that floats to 8'hEE when not driven.
module tb_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       v[2];
  logic       we[2];
  logic [7:0] addr[2];
  logic [7:0] wdata[2];
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       ram_cs, ram_we, ram_oe;
  logic [7:0] ram_addr, ram_din, ram_dout;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v[0]),
    .req0_ready (req0_ready),
    .req0_we    (we[0]),
    .req0_addr  (addr[0]),
    .req0_wdata (wdata[0]),
    .req1_valid (v[1]),
    .req1_ready (req1_ready),
    .req1_we    (we[1]),
    .req1_addr  (addr[1]),
    .req1_wdata (wdata[1]),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_oe     (ram_oe),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: write and registered read on the rising edge.
  logic [7:0] mem[256];
  logic [7:0] dq;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_din;
    if (ram_cs && !ram_we) dq <= mem[ram_addr];
  end
  assign ram_dout = (ram_cs && !ram_we && ram_oe) ? dq : 8'hEE;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [7:0] shadow[256];
  bit         in_rd;
  bit         last;
  bit         p1_v, p2_v;
  bit         p1_id, p2_id;
  logic [7:0] p1_d, p2_d;
  logic [7:0] exp_rd[2];
  bit         acc[2];

  bit         e0, e1, g0, g1, g, gi, gwe;
  logic [7:0] exp_addr;

  task automatic model_reset();
    in_rd = 0; last = 1;
    p1_v = 0; p2_v = 0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    acc[0] = 0; acc[1] = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    #1;
    if (rst) begin
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_ram", {ram_cs, ram_we, ram_oe}, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_rsp_v", {rsp1_valid, rsp0_valid}, 0);
      check("rst_rdata", {rsp1_rdata, rsp0_rdata}, 0);
      model_reset();
    end else begin
      e0 = v[0] && !(in_rd && we[0]);
      e1 = v[1] && !(in_rd && we[1]);
      g0 = e0 && (!e1 || last);
      g1 = e1 && (!e0 || !last);
      g  = g0 || g1;
      gi = g1;
      gwe = g && we[gi];
      exp_addr = g ? addr[gi] : 8'h00;
      check("ready0", req0_ready, g0);
      check("ready1", req1_ready, g1);
      check("ram_cs", ram_cs, g || in_rd);
      check("ram_we", ram_we, gwe);
      check("ram_oe", ram_oe, (g && !gwe) || in_rd);
      check("ram_addr", ram_addr, exp_addr);
      if (gwe) check("ram_din", ram_din, wdata[gi]);
      if (!g) check("ram_din_idle", ram_din, 0);
      if (p2_v) exp_rd[p2_id] = p2_d;
      check("rsp0_valid", rsp0_valid, p2_v && !p2_id);
      check("rsp1_valid", rsp1_valid, p2_v && p2_id);
      check("rsp0_rdata", rsp0_rdata, exp_rd[0]);
      check("rsp1_rdata", rsp1_rdata, exp_rd[1]);
      p2_v = p1_v; p2_id = p1_id; p2_d = p1_d;
      p1_v = g && !gwe;
      p1_id = gi;
      p1_d = shadow[exp_addr];
      if (gwe) shadow[exp_addr] = wdata[gi];
      in_rd = p1_v;
      if (g) last = gi;
      acc[0] = v[0] && req0_ready;
      acc[1] = v[1] && req1_ready;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input int i, input bit w,
                     input logic [7:0] a, input logic [7:0] d);
    v[i] = 1; we[i] = w; addr[i] = a; wdata[i] = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (acc[i]) begin
        v[i] = 0;
        return;
      end
    end
    check("put_timeout", acc[i], 1);
    v[i] = 0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k] = 8'($urandom);
      shadow[k] = mem[k];
    end
    mem[1] = 8'h11; shadow[1] = 8'h11;
    mem[2] = 8'h22; shadow[2] = 8'h22;
    mem[8'h30] = 8'h3C; shadow[8'h30] = 8'h3C;
    rst = 1;
    v[0] = 1; we[0] = 0; addr[0] = 8'h01; wdata[0] = 0;
    v[1] = 1; we[1] = 0; addr[1] = 8'h02; wdata[1] = 0;
    idle(3);
    rst = 0;
    idle(4);
    v[0] = 0; v[1] = 0;
    idle(3);
    // write then read on requester 0
    put(0, 1, 8'h10, 8'hA5);
    put(0, 0, 8'h10, 8'h00);
    idle(3);
    // continuous contention
    v[0] = 1; we[0] = 0; addr[0] = 8'h01;
    v[1] = 1; we[1] = 0; addr[1] = 8'h02;
    idle(8);
    v[0] = 0; v[1] = 0;
    idle(3);
    // write from req1 stalled behind a read from req0
    put(1, 0, 8'h05, 8'h00);
    v[0] = 1; we[0] = 0; addr[0] = 8'h30;
    v[1] = 1; we[1] = 1; addr[1] = 8'h30; wdata[1] = 8'h5A;
    for (int k = 0; k < 10 && (v[0] || v[1]); k++) begin
      @(negedge clk);
      if (acc[0]) v[0] = 0;
      if (acc[1]) v[1] = 0;
    end
    check("stall_timeout", {v[1], v[0]}, 0);
    v[0] = 0; v[1] = 0;
    put(0, 0, 8'h30, 8'h00);
    idle(3);
    // reset during the capture cycle
    put(0, 0, 8'h10, 8'h00);
    rst = 1;
    idle(2);
    rst = 0;
    put(0, 0, 8'h10, 8'h00);
    idle(3);
    // single requester streaming writes, then contention
    for (int k = 0; k < 4; k++) put(1, 1, 8'h40 + 8'(k), 8'($urandom));
    v[0] = 1; we[0] = 0; addr[0] = 8'h41;
    v[1] = 1; we[1] = 0; addr[1] = 8'h42;
    idle(4);
    v[0] = 0; v[1] = 0;
    idle(3);
    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(299) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!v[i] || acc[i]) begin
          if ($urandom_range(99) < 65) begin
            v[i] = 1;
            we[i] = 1'($urandom);
            addr[i] = 8'($urandom_range(15));
            wdata[i] = 8'($urandom);
          end else begin
            v[i] = 0;
          end
        end
      end
    end
    @(negedge clk);
    rst = 0; v[0] = 0; v[1] = 0;
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the team's single-port synchronous RAM. The RAM uses cs/we/oe control, a registered read and a tri-state output that is valid only while cs & ~we & oe. The block sits between two independent masters and the RAM. It grants one access per cycle using round-robin priority and sequences the RAM controls so each read is captured correctly. It returns read data to the requester that issued the read, with a fixed latency.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 8, RAM address width

Ports (N = 0, 1):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- reqN_valid  in  1  requester N has an access pending
- reqN_ready  out  1  access from N granted this cycle (combinational)
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_WIDTH  access address
- reqN_wdata  in  DATA_WIDTH  write data
- rspN_valid  out  1  one-cycle pulse: read data for N on rspN_rdata
- rspN_rdata  out  DATA_WIDTH  registered read data
- ram_cs, ram_we, ram_oe  out  1 each  RAM controls
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM read data (tri-stated when not reading)

## Operation
- **Handshake:** a transfer occurs when reqN_valid & reqN_ready. The requester holds valid and its payload stable until ready. reqN_ready never depends on reqN_ready of the other port.
- **Arbitration:**
  - Only one requester valid: it is eligible.
  - Both valid: grant the requester not granted most recently.
  - The last-grant pointer updates only on a grant. Its reset value favours requester 0.
- **FSM, ram_arb_state_t:** IDLE, RD_CAP.
  - IDLE: any eligible access may be granted.
    - Write grant: ram_cs=1, ram_we=1, ram_oe=0, ram_addr/ram_din from the granted requester. Next state IDLE.
    - Read grant: ram_cs=1, ram_we=0, ram_oe=1. Next state RD_CAP. Record the owner ID.
  - RD_CAP: ram_cs=1, ram_we=0, ram_oe=1 are forced so ram_dout is driven. ram_dout is registered into rsp<owner>_rdata and rsp<owner>_valid is set.
    - A read may be granted in the same cycle (pipelined). The arbitration order is unchanged, the owner ID is updated, and the state stays RD_CAP.
    - A write may not be granted; its ready stays 0. This stalls only that write. The arbiter still grants the other requester's read if one is pending.
    - No new read granted: next state IDLE, ram_addr=0.
- **No grant and not in RD_CAP:** all ram_* outputs are 0.
- **Ordering:** RAM accesses occur in grant order. A read granted the cycle after a write to the same address returns the new data.

## Timing
- Write granted in cycle T: memory is updated at the T/T+1 edge. No response is generated.
- Read granted in cycle T:
  - The RAM registers the data at the T/T+1 edge.
  - ram_dout is valid in T+1.
  - rspN_valid = 1 and rspN_rdata are valid in T+2 for exactly one cycle. Latency is 2.
- Back-to-back reads: one response per cycle, in grant order. The two responses may go to different requesters.
- **Reset (async assert, any state):**
  - Immediately: state = IDLE, pointer favours requester 0, rsp0/1_valid = 0, rsp0/1_rdata = 0.
  - While rst = 1: reqN_ready = 0 and all ram_* = 0.
  - A read in flight at reset is dropped; no response is produced.
- **Reset deassert:** a grant is possible in the first cycle rst is low.
- rspN_rdata holds its last value when rspN_valid = 0.

## Structure
- Package ram_arb_pkg:
  - ram_arb_state_t (IDLE, RD_CAP)
  - requester-ID type (1 bit)
  - localparam RD_LATENCY = 2
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], an enable for a read-only restriction, clk, rst.
  - Outputs: a one-hot grant and a pointer update on grant.
- The top level holds the FSM, the owner register, the response registers and the RAM control muxing.

## Test plan
- **Reset:** hold rst with both valid → ready = 0, ram_cs = 0, rsp_valid = 0. Release → requester 0 granted first.
- **Write then read, same requester:** req0 writes 0xA5 to address 0x10, then reads 0x10 → rsp0_valid 2 cycles after the read grant, rdata = 0xA5. rsp1_valid stays 0.
- **Contention:** both requesters hold reads continuously (addresses 0x01 and 0x02 preloaded with 0x11 and 0x22) → grants alternate 0,1,0,1. Responses alternate rsp0 = 0x11 and rsp1 = 0x22, one per cycle.
- **Write stall behind a read:** req0 read granted in T while req1 holds a write → req1_ready = 0 in T+1 (RD_CAP), granted in T+2. Memory holds the new value and the read returns the old value.
- **Reset mid-read:** assert rst in the RD_CAP cycle → no rsp_valid pulse. After release, a fresh read returns correct data with latency 2.
- **Fairness under a single requester:** only req1 valid for 4 writes → granted every cycle. The pointer then favours req0 on the next contention.
